// File: rtl/icache_fill_ctrl.sv
// I-cache miss / line-fill controller.
// Accepts a stage-2 miss, picks a one-hot victim way (round robin), issues a
// single burst read, and streams the returned beats into the data bank while
// forwarding the requested word to fetch.
// Optional feature macro: ICACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   : burst starts at the requested word and wraps around the line
//   undefined : burst starts at the line base, words in order 0..LINE_WORDS-1
//
// state | meaning
// IDLE  | waiting for a miss, no outstanding work
// REQ   | burst request held until memory accepts it
// FILL  | collecting beats, writing the data bank, forwarding the critical word
module icache_fill_ctrl #(
  parameter int WAYS       = 2,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 8,
  localparam int LINE_ADDR_W = $clog2(LINES),
  localparam int SUB_W       = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss,
  input  logic [31:0]                  miss_addr,
  input  logic                         flush,
  output logic                         busy,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ack,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata,
  output logic                         update,
  output logic [WAYS-1:0]              update_way,
  output logic [WAYS-1:0]              data_we,
  output logic [LINE_ADDR_W+SUB_W-1:0] data_addr,
  output logic [31:0]                  data_wdata,
  output logic                         fwd_valid,
  output logic [31:0]                  fwd_data,
  output logic                         fill_done
);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  localparam logic [SUB_W:0] LAST_CNT = (SUB_W+1)'(LINE_WORDS - 1);

  state_t                  state;
  logic [WAYS-1:0]         victim_q;
  logic [SUB_W:0]          cnt_q;
  logic [LINE_ADDR_W-1:0]  line_q;
  logic [SUB_W-1:0]        off_q;
  logic                    discard_q;

  logic                    beat;
  logic                    last_beat;
  logic [SUB_W-1:0]        beat_word;
  logic [WAYS-1:0]         victim_rot;
  logic [31:0]             burst_addr;
  logic                    unused_addr_bits;

  // Byte offset within a word never matters for an instruction line fill.
  assign unused_addr_bits = ^miss_addr[1:0];

  assign beat       = (state == FILL) && mem_rvalid;
  assign last_beat  = beat && (cnt_q == LAST_CNT);
  // Rotate left by one; the right-shift term wraps the top way back to way 0.
  assign victim_rot = (victim_q << 1) | (victim_q >> (WAYS - 1));

`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign burst_addr = {miss_addr[31:2], 2'b00};
  assign beat_word  = off_q + cnt_q[SUB_W-1:0];
`else
  assign burst_addr = {miss_addr[31:SUB_W+2], {(SUB_W+2){1'b0}}};
  assign beat_word  = cnt_q[SUB_W-1:0];
`endif

  // Sequencing: latch the miss, hold the request, count beats, rotate victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      victim_q  <= WAYS'(1);
      cnt_q     <= '0;
      line_q    <= '0;
      off_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss && !flush) begin
            state     <= REQ;
            line_q    <= miss_addr[SUB_W+2 +: LINE_ADDR_W];
            off_q     <= miss_addr[2 +: SUB_W];
            cnt_q     <= '0;
            discard_q <= 1'b0;
          end
        end
        REQ: begin
          // An accepted burst cannot be recalled, so ack beats a same-cycle flush.
          if (mem_ack) begin
            state     <= FILL;
            discard_q <= flush;
          end else if (flush) begin
            state <= IDLE;
          end
        end
        FILL: begin
          if (flush) discard_q <= 1'b1;
          if (beat) cnt_q <= cnt_q + (SUB_W+1)'(1);
          if (last_beat) begin
            state     <= IDLE;
            victim_q  <= victim_rot;
            cnt_q     <= '0;
            discard_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the state and the current beat so they line up with memory.
  always_comb begin
    busy       = (state != IDLE);
    mem_req    = (state == REQ);
    mem_addr   = mem_req ? burst_addr : 32'h0;
    update     = mem_req && mem_ack;
    update_way = update ? victim_q : '0;
    data_we    = beat ? victim_q : '0;
    data_addr  = {line_q, beat_word};
    data_wdata = mem_rdata;
    fwd_valid  = beat && (beat_word == off_q) && !discard_q && !flush;
    fwd_data   = mem_rdata;
    fill_done  = last_beat;
  end

endmodule
